// File: rtl/fpga9685_pkg.sv
// rtl/fpga9685_pkg.sv - shared constants, scan FSM encoding and out-of-range read rule
package fpga9685_pkg;

  localparam int REGISTERS = 16;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  typedef enum logic {
    WIN_SCAN = 1'b0,
    WIN_HOST = 1'b1
  } winner_e;

  // Reads of ids beyond the bank return the id with its nibbles swapped.
  function automatic logic [7:0] oor_read_data(input logic [7:0] addr);
    return {addr[3:0], addr[7:4]};
  endfunction

endpackage

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - single-port register bank, sync write, registered read, sync clear
module reg_bank #(
  parameter int DEPTH = fpga9685_pkg::REGISTERS,
  parameter int WIDTH = fpga9685_pkg::DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [WIDTH-1:0]            rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q   <= '0;
      rdata_q <= '0;
    end else if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - host/scan arbitration over reg_bank with periodic coherent shadow snapshot
module reg_bank_arbiter #(
  parameter int REGISTERS = fpga9685_pkg::REGISTERS,
  parameter int DATA_W    = fpga9685_pkg::DATA_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          i2c_req_i,
  input  logic                          i2c_we_i,
  input  logic [7:0]                    i2c_addr_i,
  input  logic [DATA_W-1:0]             i2c_wdata_i,
  output logic                          i2c_gnt_o,
  output logic                          i2c_rvalid_o,
  output logic [DATA_W-1:0]             i2c_rdata_o,
  input  logic                          period_tick_i,
  output logic [REGISTERS*DATA_W-1:0]   shadow_o,
  output logic                          shadow_valid_o,
  output logic                          busy_o,
  output logic                          overrun_o
);

  import fpga9685_pkg::*;

  localparam int BANK_AW = $clog2(REGISTERS);
  localparam int IDX_W   = BANK_AW + 1;
  localparam logic [BANK_AW-1:0] LAST_SLOT = BANK_AW'(REGISTERS - 1);

  scan_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  winner_e          last_winner_q, last_winner_d;
  logic             drop;

  logic             rd_host_q, rd_host_oor_q;
  logic [DATA_W-1:0] oor_data_q, rdata_hold_q, host_rdata;
  logic             rd_scan_q;
  logic [BANK_AW-1:0] rd_slot_q;
  logic             overrun_q;

  logic [REGISTERS-1:0][DATA_W-1:0] staging_q, staging_d, shadow_q;

  logic scan_elig, host_elig, scan_req, contended, host_gnt, scan_gnt;
  logic host_in_range;
  logic bank_en, bank_we;
  logic [BANK_AW-1:0] bank_addr;
  logic [DATA_W-1:0]  bank_rdata;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a tick seen in DONE is folded straight into the restart decision
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    drop      = 1'b0;
    if (period_tick_i && state_q != ST_IDLE) begin
      if (pending_q) begin
        drop = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end
    unique case (state_q)
      ST_IDLE: begin
        if (period_tick_i) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (scan_gnt) begin
          idx_d = idx_q + 1'b1;
        end
        if (rd_scan_q && rd_slot_q == LAST_SLOT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (pending_d) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o         = (state_q != ST_IDLE);
    shadow_valid_o = (state_q == ST_DONE);
    scan_elig      = (state_q == ST_SCAN) && (int'(idx_q) < REGISTERS);
  end

  // Grants are suppressed during reset so nothing is issued to the bank being cleared
  always_comb begin
    host_elig     = i2c_req_i && !rst_i;
    scan_req      = scan_elig && !rst_i;
    contended     = host_elig && scan_req;
    host_gnt      = host_elig && (!scan_req || last_winner_q == WIN_SCAN);
    scan_gnt      = scan_req && !host_gnt;
    last_winner_d = contended ? (host_gnt ? WIN_HOST : WIN_SCAN) : last_winner_q;
    host_in_range = int'(i2c_addr_i) < REGISTERS;
    bank_en       = scan_gnt || (host_gnt && host_in_range);
    bank_we       = host_gnt && i2c_we_i;
    bank_addr     = scan_gnt ? idx_q[BANK_AW-1:0] : i2c_addr_i[BANK_AW-1:0];
  end

  always_comb begin
    staging_d = staging_q;
    if (rd_scan_q) begin
      staging_d[rd_slot_q] = bank_rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q         <= '0;
      pending_q     <= 1'b0;
      last_winner_q <= WIN_SCAN;
      rd_host_q     <= 1'b0;
      rd_host_oor_q <= 1'b0;
      oor_data_q    <= '0;
      rdata_hold_q  <= '0;
      rd_scan_q     <= 1'b0;
      rd_slot_q     <= '0;
      overrun_q     <= 1'b0;
      staging_q     <= '0;
      shadow_q      <= '0;
    end else begin
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      last_winner_q <= last_winner_d;
      rd_host_q     <= host_gnt && !i2c_we_i;
      rd_host_oor_q <= !host_in_range;
      oor_data_q    <= DATA_W'(oor_read_data(i2c_addr_i));
      rd_scan_q     <= scan_gnt;
      rd_slot_q     <= idx_q[BANK_AW-1:0];
      overrun_q     <= drop;
      staging_q     <= staging_d;
      if (rd_host_q) begin
        rdata_hold_q <= host_rdata;
      end
      // Shadow takes the completed staging (including the final slot) as DONE is entered
      if (state_q == ST_SCAN && state_d == ST_DONE) begin
        shadow_q <= staging_d;
      end
    end
  end

  assign host_rdata   = rd_host_oor_q ? oor_data_q : bank_rdata;
  assign i2c_gnt_o    = host_gnt;
  assign i2c_rvalid_o = rd_host_q;
  assign i2c_rdata_o  = rd_host_q ? host_rdata : rdata_hold_q;
  assign shadow_o     = shadow_q;
  assign overrun_o    = overrun_q;

  reg_bank #(
    .DEPTH (REGISTERS),
    .WIDTH (DATA_W),
    .AW    (BANK_AW)
  ) u_bank (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (bank_en),
    .we_i    (bank_we),
    .addr_i  (bank_addr),
    .wdata_i (i2c_wdata_i),
    .rdata_o (bank_rdata)
  );

endmodule
